// File: rtl/thresh_linebuf.sv
// Double-threshold classifier with a two-row line buffer; emits one 3-pixel column (rows y-2, y-1, y) per accepted pixel.
// Optional build macro THRESH_BORDER_ZERO_EN forces frame-border pixels to class 0.
module thresh_linebuf #(
  parameter int IMG_WIDTH  = 960,
  parameter int IMG_HEIGHT = 720,
  parameter int MAG_WIDTH  = 8,
  parameter int BIT_LENGTH = 5,
  parameter int LOW_TH     = 20,
  parameter int HIGH_TH    = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  enable,
  input  logic [MAG_WIDTH-1:0]  mag_in,
  output logic [BIT_LENGTH-1:0] pixel_out0,
  output logic [BIT_LENGTH-1:0] pixel_out1,
  output logic [BIT_LENGTH-1:0] pixel_out2,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  stall_err
);

  localparam int CW = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 4) ? $clog2(IMG_HEIGHT) : 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_STREAM, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  stall_q, stall_d;
  logic                  pend_q, pend_d;
  logic                  valid_q, valid_d;
  logic                  fdone_q, fdone_d;
  logic [BIT_LENGTH-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;

  logic [1:0] lb_a [IMG_WIDTH];
  logic [1:0] lb_b [IMG_WIDTH];
  logic [1:0] rd_a, rd_b, cls;
  logic       accept, col_last, row_last;

  assign accept   = enable && (state_q != S_DONE);
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign rd_a     = lb_a[col_q];
  assign rd_b     = lb_b[col_q];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cls = 2'd0;
    if (mag_in >= MAG_WIDTH'(HIGH_TH))     cls = 2'd2;
    else if (mag_in >= MAG_WIDTH'(LOW_TH)) cls = 2'd1;
`ifdef THRESH_BORDER_ZERO_EN
    if (row_q == '0 || row_last || col_q == '0 || col_last) cls = 2'd0;
`endif
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    stall_d = stall_q;
    pend_d  = 1'b0;
    fdone_d = pend_q;
    valid_d = 1'b0;
    p0_d    = '0;
    p1_d    = '0;
    p2_d    = '0;

    unique case (state_q)
      S_IDLE:   if (enable) state_d = S_FILL;
      S_FILL:   if (enable && row_q == RW'(1) && col_last) state_d = S_STREAM;
      S_STREAM: begin
        if (enable && row_last && col_last) begin
          state_d = S_DONE;
          pend_d  = 1'b1;
        end else if (!enable) begin
          // Downstream treats a valid_out drop as end of data, so a gap is only flagged.
          stall_d = 1'b1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_IDLE;
          col_d   = '0;
          row_d   = '0;
          stall_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      if (row_q >= RW'(2)) begin
        valid_d = 1'b1;
        p0_d    = BIT_LENGTH'(rd_a);
        p1_d    = BIT_LENGTH'(rd_b);
        p2_d    = BIT_LENGTH'(cls);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      stall_q <= 1'b0;
      pend_q  <= 1'b0;
      fdone_q <= 1'b0;
      valid_q <= 1'b0;
      p0_q    <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      stall_q <= stall_d;
      pend_q  <= pend_d;
      fdone_q <= fdone_d;
      valid_q <= valid_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
    end
  end

  // NOTE: line buffers carry no reset; rows 0 and 1 overwrite every entry before it is ever emitted.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_a[col_q] <= rd_b;
      lb_b[col_q] <= cls;
    end
  end

  assign pixel_out0 = p0_q;
  assign pixel_out1 = p1_q;
  assign pixel_out2 = p2_q;
  assign valid_out  = valid_q;
  assign frame_done = fdone_q;
  assign stall_err  = stall_q;

endmodule

// File: tb/tb_thresh_linebuf.sv
// Self-checking bench for thresh_linebuf on a 4x4 frame: frame-level model plus hand-computed column checks.
// Build with THRESH_BORDER_ZERO_EN defined to exercise the border-zero variant.
module tb_thresh_linebuf;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int LO = 20;
  localparam int HI = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] mag_in = '0;
  logic [4:0] pixel_out0, pixel_out1, pixel_out2;
  logic       valid_out, frame_done, stall_err;

  thresh_linebuf #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_WIDTH(8), .BIT_LENGTH(5),
    .LOW_TH(LO), .HIGH_TH(HI)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .enable(enable), .mag_in(mag_in),
    .pixel_out0(pixel_out0), .pixel_out1(pixel_out1), .pixel_out2(pixel_out2),
    .valid_out(valid_out), .frame_done(frame_done), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int m_img [H][W];
  int m_idx = 0;
  bit m_done = 0, m_stall = 0, m_pend = 0;
  int exp_valid = 0, exp_p0 = 0, exp_p1 = 0, exp_p2 = 0, exp_fd = 0, exp_stall = 0;
  int cyc = 0;

  function automatic int m_cls(int mag, int r, int c);
`ifdef THRESH_BORDER_ZERO_EN
    if (r == 0 || r == H-1 || c == 0 || c == W-1) return 0;
`endif
    if (mag >= HI) return 2;
    if (mag >= LO) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_idx = 0; m_done = 0; m_stall = 0; m_pend = 0;
      exp_valid = 0; exp_p0 = 0; exp_p1 = 0; exp_p2 = 0; exp_fd = 0; exp_stall = 0;
    end else begin
      exp_fd = int'(m_pend);
      m_pend = 0;
      exp_valid = 0; exp_p0 = 0; exp_p1 = 0; exp_p2 = 0;
      if (m_done) begin
        if (start) begin
          m_done = 0; m_idx = 0; m_stall = 0;
        end
      end else if (enable) begin
        int r, c, k;
        r = m_idx / W;
        c = m_idx % W;
        k = m_cls(int'(mag_in), r, c);
        m_img[r][c] = k;
        if (r >= 2) begin
          exp_valid = 1;
          exp_p0 = m_img[r-2][c];
          exp_p1 = m_img[r-1][c];
          exp_p2 = k;
        end
        m_idx++;
        if (m_idx == W*H) begin
          m_done = 1;
          m_pend = 1;
        end
      end else if (m_idx >= 2*W) begin
        m_stall = 1;
      end
      exp_stall = int'(m_stall);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 0;
  int log_q[$];
  int fd_cnt = 0, fd_cyc = 0, last_valid_cyc = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (!reset) begin
        check("reset_outputs", int'({pixel_out0, pixel_out1, pixel_out2, valid_out, frame_done, stall_err}), 0);
      end else begin
        check("valid_out",  int'(valid_out),  exp_valid);
        check("pixel_out0", int'(pixel_out0), exp_p0);
        check("pixel_out1", int'(pixel_out1), exp_p1);
        check("pixel_out2", int'(pixel_out2), exp_p2);
        check("frame_done", int'(frame_done), exp_fd);
        check("stall_err",  int'(stall_err),  exp_stall);
        if (valid_out) begin
          log_q.push_back(int'(pixel_out0) * 100 + int'(pixel_out1) * 10 + int'(pixel_out2));
          last_valid_cyc = cyc;
        end
        if (frame_done) begin
          fd_cnt++;
          fd_cyc = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int fm [H][W];

  task automatic drive(input logic en, input int mag, input logic st);
    enable = en;
    mag_in = 8'(mag);
    start  = st;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rows(input int a, input int b, input int c, input int d);
    for (int x = 0; x < W; x++) begin
      fm[0][x] = a; fm[1][x] = b; fm[2][x] = c; fm[3][x] = d;
    end
  endtask

  task automatic wait_frame_done();
    int base;
    base = fd_cnt;
    for (int i = 0; i < 10 && fd_cnt == base; i++) drive(0, 0, 0);
    check("frame_done_seen", fd_cnt, base + 1);
    drive(0, 0, 0);
    drive(0, 0, 0);
    check("frame_done_once", fd_cnt, base + 1);
  endtask

  task automatic send_frame(input int gap_after);
    log_q.delete();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        drive(1, fm[r][c], 0);
        if (r*W + c == gap_after) begin
          drive(0, 0, 0);
          drive(0, 0, 0);
          check("gap_stall_err", int'(stall_err), 1);
          check("gap_valid_low", int'(valid_out), 0);
        end
      end
    end
    enable = 0;
    wait_frame_done();
    check("valid_count", log_q.size(), W*(H-2));
  endtask

  task automatic check_cols(input string tag, input int e0, input int e1, input int e2, input int e3,
                            input int f0, input int f1, input int f2, input int f3);
    int e[8];
    e = '{e0, e1, e2, e3, f0, f1, f2, f3};
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_col%0d", tag, i), (i < log_q.size()) ? log_q[i] : -1, e[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset held with random activity, then idle after release
    @(posedge clk);
    #1;
    cmp_en = 1;
    for (int i = 0; i < 5; i++) drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 0);
    reset = 1;
    for (int i = 0; i < 3; i++) drive(0, 0, 0);
    check("idle_valid", int'(valid_out), 0);
    check("idle_stall", int'(stall_err), 0);

    // 2. threshold boundaries on row 2
    set_rows(0, 0, 0, 0);
    fm[2][0] = 19; fm[2][1] = 20; fm[2][2] = 49; fm[2][3] = 50;
    send_frame(-1);
`ifndef THRESH_BORDER_ZERO_EN
    check_cols("thresh", 0, 1, 1, 2, 0, 10, 10, 20);
`endif
    drive(0, 0, 1);

    // 3. continuous frame
    set_rows(60, 30, 0, 55);
    send_frame(-1);
    check("fd_after_last_valid", fd_cyc, last_valid_cyc + 1);
`ifndef THRESH_BORDER_ZERO_EN
    check_cols("cont", 210, 210, 210, 210, 102, 102, 102, 102);
`endif

    // 4. enable ignored in DONE; start+enable together, start wins
    for (int i = 0; i < 5; i++) drive(1, 60, 0);
    check("done_no_valid", log_q.size(), W*(H-2));
    check("done_no_fd", fd_cnt, 2);
    drive(1, 60, 1);
    send_frame(-1);
`ifndef THRESH_BORDER_ZERO_EN
    check_cols("rearm", 210, 210, 210, 210, 102, 102, 102, 102);
`endif
    drive(0, 0, 1);

    // 5. two-cycle gap after (row 2, col 1)
    send_frame(2*W + 1);
`ifndef THRESH_BORDER_ZERO_EN
    check_cols("gap", 210, 210, 210, 210, 102, 102, 102, 102);
`endif
    drive(0, 0, 1);
    check("start_clears_stall", int'(stall_err), 0);

    // reset mid-frame: no frame_done, clean restart from IDLE
    for (int i = 0; i < 6; i++) drive(1, 60, 0);
    reset = 0;
    drive(0, 0, 0);
    drive(0, 0, 0);
    reset = 1;
    drive(0, 0, 0);
    check("midreset_no_fd", fd_cnt, 4);
    send_frame(-1);
`ifndef THRESH_BORDER_ZERO_EN
    check_cols("after_reset", 210, 210, 210, 210, 102, 102, 102, 102);
`endif
    drive(0, 0, 1);

`ifdef THRESH_BORDER_ZERO_EN
    // 6. border suppression on an all-60 frame
    set_rows(60, 60, 60, 60);
    send_frame(-1);
    check_cols("border", 0, 22, 22, 0, 0, 220, 220, 0);
    drive(0, 0, 1);
`endif

    drive(0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
